// File: rtl/bus_copy_master_pkg.sv
// bus_copy_master_pkg
//   Shared definitions for the peripheral-bus copy master:
//   - FSM state encoding (IDLE, READ, WRITE, WCHK, DONE)
//   - peripheral address map constants (timer TH/TL/TCON, LED, SWITCH, DIGI)
//   - the bus poison value a responder drives on unmapped reads
package bus_copy_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_WCHK  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED    = 32'h4000_0010;
  localparam logic [31:0] ADDR_SWITCH = 32'h4000_0014;
  localparam logic [31:0] ADDR_DIGI   = 32'h4000_0018;

  localparam logic [31:0] BUS_POISON  = 32'hcdcd_cdcd;

endpackage

// File: rtl/bus_copy_master.sv
// bus_copy_master
//   Second bus initiator on the memory-mapped peripheral bus. Executes word
//   copy commands: read a word at src, write it to dst, repeat len times,
//   optionally incrementing src and/or dst by ADDR_STEP after each word.
//   Completion and the first access fault are reported to the command side.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (see below)
//   cmd_src, cmd_dst      first source / destination byte address
//   cmd_len               number of words (0 allowed: completes immediately)
//   cmd_src_inc/dst_inc   1 = advance that address by ADDR_STEP per word
//   busy                  command in progress (cycle after accept .. DONE)
//   done                  one-cycle completion pulse (success or error)
//   err, err_addr         status of the last command and the faulting address
//   words_done            words written successfully in current/last command
//   rd, wr, addr, wdata   bus request outputs, decoded from flops only
//   rdata, r_accessible   combinational read response (same cycle as rd)
//   w_accessible          registered write response (cycle after wr)
//   state_dbg             current FSM state, for observation
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high exactly when the FSM is IDLE; cmd_valid in any other state
// is ignored and the command fields are only sampled at the accepting edge.
module bus_copy_master
  import bus_copy_master_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_src_inc,
  input  logic             cmd_dst_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [LEN_W-1:0] words_done,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  input  logic             r_accessible,
  input  logic             w_accessible,
  output state_t           state_dbg
);

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [31:0]      STEP     = 32'(ADDR_STEP);

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q, err_addr_q;
  logic [LEN_W-1:0] rem_q, words_done_q;
  logic             src_inc_q, dst_inc_q, err_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = (cmd_len == LEN_ZERO) ? ST_DONE : ST_READ;
      end
      ST_READ:  state_d = r_accessible ? ST_WRITE : ST_DONE;
      ST_WRITE: state_d = ST_WCHK;
      ST_WCHK: begin
        // rem_q still holds the count before this word is retired
        if (!w_accessible || rem_q == LEN_ONE) state_d = ST_DONE;
        else                                   state_d = ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      rem_q        <= '0;
      src_inc_q    <= 1'b0;
      dst_inc_q    <= 1'b0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      words_done_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            src_q        <= cmd_src;
            dst_q        <= cmd_dst;
            rem_q        <= cmd_len;
            src_inc_q    <= cmd_src_inc;
            dst_inc_q    <= cmd_dst_inc;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            words_done_q <= '0;
          end
        end
        ST_READ: begin
          if (r_accessible) begin
            data_q <= rdata;
          end else begin
            err_q      <= 1'b1;
            err_addr_q <= src_q;
          end
        end
        ST_WCHK: begin
          if (!w_accessible) begin
            err_q      <= 1'b1;
            err_addr_q <= dst_q;
          end else begin
            words_done_q <= words_done_q + LEN_ONE;
            rem_q        <= rem_q - LEN_ONE;
            // Wraps modulo 2^32 by construction of the 32-bit add
            if (src_inc_q) src_q <= src_q + STEP;
            if (dst_inc_q) dst_q <= dst_q + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and status outputs: pure decode of registered state
  always_comb begin
    rd    = (state_q == ST_READ);
    wr    = (state_q == ST_WRITE);
    addr  = '0;
    wdata = '0;
    case (state_q)
      ST_READ:  addr = src_q;
      ST_WRITE: begin
        addr  = dst_q;
        wdata = data_q;
      end
      ST_WCHK:  addr = dst_q;
      default:  ;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign err_addr   = err_addr_q;
  assign words_done = words_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// tb_bus_copy_master
//   Bench for bus_copy_master with a behavioural peripheral responder and a
//   command-level reference model (memory image + expected bus operations).
module tb_bus_copy_master;
  import bus_copy_master_pkg::*;

  localparam int LEN_W = 16;
  localparam int NMEM  = 10;
  localparam int OP_W  = 65;  // {is_write, addr, write data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             cmd_valid, cmd_ready;
  logic [31:0]      cmd_src, cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_src_inc, cmd_dst_inc;
  logic             busy, done, err;
  logic [31:0]      err_addr;
  logic [LEN_W-1:0] words_done;
  logic             rd, wr;
  logic [31:0]      addr, wdata, rdata;
  logic             r_accessible, w_accessible;
  state_t           state_dbg;

  bus_copy_master #(.LEN_W(LEN_W), .ADDR_STEP(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_src_inc(cmd_src_inc), .cmd_dst_inc(cmd_dst_inc),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .words_done(words_done),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .r_accessible(r_accessible), .w_accessible(w_accessible),
    .state_dbg(state_dbg)
  );

  // ---------------- address map shared by responder and model ----------------
  function automatic int map_idx(input logic [31:0] a);
    case (a)
      ADDR_TH:       return 0;
      ADDR_TL:       return 1;
      ADDR_TCON:     return 2;
      ADDR_LED:      return 3;
      ADDR_SWITCH:   return 4;
      ADDR_DIGI:     return 5;
      32'hFFFF_FFF8: return 6;
      32'hFFFF_FFFC: return 7;
      32'h0000_0000: return 8;
      32'h0000_0004: return 9;
      default:       return -1;
    endcase
  endfunction

  // ---------------- responder ----------------
  logic [31:0] seed    [NMEM];
  logic [31:0] mem     [NMEM];
  logic [31:0] exp_mem [NMEM];
  int          r_idx;

  assign r_idx        = map_idx(addr);
  assign r_accessible = (r_idx >= 0);
  assign rdata        = (r_idx >= 0) ? mem[r_idx] : BUS_POISON;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NMEM; i++) mem[i] <= seed[i];
      w_accessible <= 1'b0;
    end else begin
      w_accessible <= 1'b0;
      if (wr && map_idx(addr) >= 0 && addr != ADDR_SWITCH) begin
        mem[map_idx(addr)] <= wdata;
        w_accessible       <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [OP_W-1:0] exp_q[$];
  logic [OP_W-1:0] obs_q[$];

  task automatic check(input string tag, input logic [OP_W-1:0] got,
                       input logic [OP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic             exp_err;
  logic [31:0]      exp_err_addr;
  int               exp_words;
  int               exp_done_c;

  // Walks the command word by word over the model memory image.
  task automatic model_cmd(input logic [31:0] s_in, d_in, input int len,
                           input bit si, di);
    logic [31:0] s, d, data;
    int ri, wi;
    s = s_in; d = d_in;
    exp_err = 1'b0; exp_err_addr = '0; exp_words = 0;
    exp_done_c = 3 * len + 1;
    for (int k = 1; k <= len; k++) begin
      ri = map_idx(s);
      exp_q.push_back({1'b0, s, 32'h0});
      if (ri < 0) begin
        exp_err = 1'b1; exp_err_addr = s; exp_done_c = 3 * k - 1;
        return;
      end
      data = exp_mem[ri];
      exp_q.push_back({1'b1, d, data});
      wi = map_idx(d);
      if (wi < 0 || d == ADDR_SWITCH) begin
        exp_err = 1'b1; exp_err_addr = d; exp_done_c = 3 * k + 1;
        return;
      end
      exp_mem[wi] = data;
      exp_words++;
      if (si) s = s + 32'd4;
      if (di) d = d + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input string name, input logic [31:0] s, d,
                         input int len, input bit si, di, input bit hold);
    int  done_c, budget;
    bit  bad_busy, bad_ready, both;
    exp_q.delete(); obs_q.delete();
    model_cmd(s, d, len, si, di);
    budget = 3 * len + 8;
    done_c = -1; bad_busy = 0; bad_ready = 0; both = 0;

    @(negedge clk);
    check({name, ".ready_idle"}, 65'(cmd_ready), 65'd1);
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = LEN_W'(len);
    cmd_src_inc = si; cmd_dst_inc = di;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (rd) obs_q.push_back({1'b0, addr, 32'h0});
      if (wr) obs_q.push_back({1'b1, addr, wdata});
      if (rd && wr) both = 1;
      if (!busy) bad_busy = 1;
      if (cmd_ready) bad_ready = 1;
      if (done) begin done_c = c; break; end
    end
    if (done_c < 0) check({name, ".done_timeout"}, 65'd0, 65'd1);
    check({name, ".done_cycle"}, 65'(done_c), 65'(exp_done_c));
    check({name, ".busy_window"}, 65'(bad_busy), 65'd0);
    check({name, ".ready_low"}, 65'(bad_ready), 65'd0);
    check({name, ".one_strobe"}, 65'(both), 65'd0);
    check({name, ".err"}, 65'(err), 65'(exp_err));
    check({name, ".err_addr"}, 65'(err_addr), 65'(exp_err_addr));
    check({name, ".words_done"}, 65'(words_done), 65'(exp_words));
    check({name, ".op_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s.op%0d", name, i), obs_q[i], exp_q[i]);

    // Cycle after done: back in idle, pulse gone
    @(posedge clk); #1;
    check({name, ".post_done"}, 65'(done), 65'd0);
    check({name, ".post_busy"}, 65'(busy), 65'd0);
    check({name, ".post_ready"}, 65'(cmd_ready), 65'd1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check({name, ".no_reaccept"}, 65'(busy), 65'd0);
    for (int i = 0; i < NMEM; i++)
      check($sformatf("%s.mem%0d", name, i), 65'(mem[i]), 65'(exp_mem[i]));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] pick [10] = '{ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_SWITCH,
                             ADDR_DIGI, 32'hFFFF_FFF8, 32'h4000_0020,
                             32'h4000_000C, 32'h4000_0011};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_src_inc = 1'b0; cmd_dst_inc = 1'b0;
    for (int i = 0; i < NMEM; i++) seed[i] = $urandom;
    seed[4] = 32'h0000_00A5;  // switch
    seed[8] = 32'h0000_0007;  // scratch word at address 0
    for (int i = 0; i < NMEM; i++) exp_mem[i] = seed[i];
    repeat (3) @(posedge clk);
    #1;
    check("rst.rd", 65'(rd), 65'd0);
    check("rst.wr", 65'(wr), 65'd0);
    check("rst.addr", 65'(addr), 65'd0);
    check("rst.wdata", 65'(wdata), 65'd0);
    check("rst.busy", 65'(busy), 65'd0);
    check("rst.done", 65'(done), 65'd0);
    check("rst.err", 65'(err), 65'd0);
    check("rst.err_addr", 65'(err_addr), 65'd0);
    check("rst.words_done", 65'(words_done), 65'd0);
    check("rst.cmd_ready", 65'(cmd_ready), 65'd1);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    run_cmd("sw2led", ADDR_SWITCH, ADDR_LED, 1, 0, 0, 0);
    check("sw2led.led_value", 65'(mem[3]), 65'h0A5);
    run_cmd("unmapped_src", 32'h4000_0020, ADDR_LED, 3, 0, 0, 0);
    run_cmd("ro_dst", ADDR_TH, ADDR_SWITCH, 2, 0, 0, 0);
    run_cmd("len0", ADDR_TH, ADDR_TL, 0, 0, 0, 0);
    run_cmd("th7", 32'h0000_0000, ADDR_TH, 1, 0, 0, 0);
    run_cmd("th_tl", ADDR_TH, ADDR_TL, 2, 1, 0, 1);
    check("th_tl.tl_value", 65'(mem[1]), 65'd7);
    run_cmd("src_wrap", 32'hFFFF_FFF8, ADDR_DIGI, 4, 1, 0, 0);
    run_cmd("dst_wrap", ADDR_LED, 32'hFFFF_FFF8, 4, 0, 1, 0);

    // Reset during WRITE of word 2
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = ADDR_SWITCH; cmd_dst = ADDR_DIGI; cmd_len = 16'd3;
    cmd_src_inc = 1'b0; cmd_dst_inc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_rst.in_write", 65'(wr), 65'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst.rd", 65'(rd), 65'd0);
    check("mid_rst.wr", 65'(wr), 65'd0);
    check("mid_rst.busy", 65'(busy), 65'd0);
    check("mid_rst.done", 65'(done), 65'd0);
    check("mid_rst.cmd_ready", 65'(cmd_ready), 65'd1);
    check("mid_rst.words_done", 65'(words_done), 65'd0);
    reset = 1'b0;
    for (int i = 0; i < NMEM; i++) exp_mem[i] = seed[i];

    // Randomized commands
    for (int t = 0; t < 25; t++) begin
      run_cmd($sformatf("rnd%0d", t), pick[$urandom_range(0, 9)],
              pick[$urandom_range(0, 9)], int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
